// File: rtl/transmit_16_qam_if.sv
// DAC pin bundle for the 16-QAM transmitter.
// The transmitter drives it through the master modport; the DAC model or the board side uses slave.
interface transmit_16_qam_if #(
    parameter int BIT_DAC = 14
);
    logic               PLL_OUT_DA;
    logic               DA_WRTA;
    logic               DA_MODE;
    logic [BIT_DAC-1:0] DAC_OUT;

    modport master (
        output PLL_OUT_DA,
        output DA_WRTA,
        output DA_MODE,
        output DAC_OUT
    );

    modport slave (
        input PLL_OUT_DA,
        input DA_WRTA,
        input DA_MODE,
        input DAC_OUT
    );
endinterface

// File: rtl/transmit_16_qam.sv
// 16-QAM transmitter: PRBS-7 bits, Gray-mapped I/Q, rectangular pulses, fs/4 mixing,
// offset-binary samples for an external DAC.
module transmit_16_qam #(
    parameter int BIT_DAC = 14,
    parameter int SPS     = 8,
    parameter int AMP     = 2047
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    transmit_16_qam_if.master dac
);

    localparam int CW = (SPS > 2) ? $clog2(SPS) : 1;
    localparam int W  = BIT_DAC + 1;

    localparam logic [CW-1:0]      SYM_LAST = CW'(SPS - 1);
    localparam logic signed [W-1:0] MID_C   = W'(2 ** (BIT_DAC - 1));
    localparam logic signed [W-1:0] AMP_C   = W'(AMP);
    localparam logic [BIT_DAC-1:0] DAC_MID  = BIT_DAC'(2 ** (BIT_DAC - 1));

    logic [6:0]         lfsr_r;
    logic [CW-1:0]      sym_cnt_r;
    logic [1:0]         phase_r;
    logic signed [2:0]  i_lvl_r;
    logic signed [2:0]  q_lvl_r;
    logic [BIT_DAC-1:0] dac_r;

    logic signed [3:0]   i_ext_s;
    logic signed [3:0]   q_ext_s;
    logic signed [3:0]   mix_s;
    logic signed [W-1:0] code_s;
    logic [BIT_DAC-1:0]  dac_next_s;

    // Two Gray-coded bits to one amplitude level.
    function automatic logic signed [2:0] gray_level(input logic [1:0] bits);
        logic signed [2:0] lvl;
        case (bits)
            2'b00:   lvl = -3'sd3;
            2'b01:   lvl = -3'sd1;
            2'b11:   lvl = 3'sd1;
            2'b10:   lvl = 3'sd3;
            default: lvl = 3'sd0;
        endcase
        return lvl;
    endfunction

    // PRBS-7 generator, symbol counter and carrier phase; all free running.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            lfsr_r    <= 7'h7F;
            sym_cnt_r <= {CW{1'b0}};
            phase_r   <= 2'd0;
        end else begin
            lfsr_r    <= {lfsr_r[5:0], lfsr_r[6] ^ lfsr_r[5]};
            sym_cnt_r <= (sym_cnt_r == SYM_LAST) ? {CW{1'b0}} : sym_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            phase_r   <= phase_r + 2'd1;
        end
    end

    // Symbol latch: levels are held for SPS samples.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            i_lvl_r <= 3'sd0;
            q_lvl_r <= 3'sd0;
        end else if (sym_cnt_r == {CW{1'b0}}) begin
            i_lvl_r <= gray_level(lfsr_r[3:2]);
            q_lvl_r <= gray_level(lfsr_r[1:0]);
        end else begin
            i_lvl_r <= i_lvl_r;
            q_lvl_r <= q_lvl_r;
        end
    end

    assign i_ext_s = {i_lvl_r[2], i_lvl_r};
    assign q_ext_s = {q_lvl_r[2], q_lvl_r};

    // fs/4 mixer: cos = 1,0,-1,0 and sin = 0,1,0,-1, so s = I*cos - Q*sin.
    always_comb begin
        mix_s = 4'sd0;
        case (phase_r)
            2'd0:    mix_s = i_ext_s;
            2'd1:    mix_s = -q_ext_s;
            2'd2:    mix_s = -i_ext_s;
            2'd3:    mix_s = q_ext_s;
            default: mix_s = 4'sd0;
        endcase
    end

    // Offset-binary conversion; the clamp only guards against an illegal AMP choice.
    always_comb begin
        code_s     = MID_C + W'(mix_s) * AMP_C;
        dac_next_s = DAC_MID;
        if (code_s[W-1]) begin
            dac_next_s = {BIT_DAC{1'b0}};
        end else begin
            dac_next_s = code_s[BIT_DAC-1:0];
        end
    end

    // Registered DAC sample.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            dac_r <= DAC_MID;
        end else begin
            dac_r <= dac_next_s;
        end
    end

    // Strobes rise mid-cycle, while DAC_OUT is stable; they run through reset.
    assign dac.PLL_OUT_DA = ~CLOCK_50;
    assign dac.DA_WRTA    = ~CLOCK_50;
    assign dac.DA_MODE    = 1'b1;
    assign dac.DAC_OUT    = dac_r;

endmodule

// File: tb/tb_transmit_16_qam.sv
// Directed bench for transmit_16_qam: reset, first samples, mapping, periodicity,
// mid-run reset and phase symmetry.
module tb_transmit_16_qam;

    localparam int SPS  = 8;
    localparam int NSMP = 256 * SPS;
    localparam int PER  = 127 * SPS;

    logic CLOCK_50;
    logic RESET;

    transmit_16_qam_if #(.BIT_DAC(14)) dac_if ();

    transmit_16_qam #(.BIT_DAC(14), .SPS(SPS), .AMP(2047)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .dac      (dac_if.master)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int samp [0:NSMP];
    int first_exp [1:5] = '{8192, 6145, 6145, 10239, 10239};

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gray(input logic [1:0] b);
        case (b)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            2'b10:   return 3;
            default: return 0;
        endcase
    endfunction

    // Capture n edges after a release that happened at a falling edge.
    task automatic capture(input int n);
        for (int e = 1; e <= n; e++) begin
            @(posedge CLOCK_50);
            #1;
            samp[e] = int'(dac_if.DAC_OUT);
        end
    endtask

    initial begin
        logic [6:0] m;
        logic [3:0] sym;
        logic [15:0] seen;
        int illegal, mism, v;

        RESET = 1'b0;
        #25;
        check("rst_dac", int'(dac_if.DAC_OUT), 8192);
        check("rst_mode", int'(dac_if.DA_MODE), 1);
        check("rst_pll_lo_clk", int'(dac_if.PLL_OUT_DA), 1);
        check("rst_wrta_lo_clk", int'(dac_if.DA_WRTA), 1);
        #10;
        check("rst_pll_hi_clk", int'(dac_if.PLL_OUT_DA), 0);
        check("rst_wrta_hi_clk", int'(dac_if.DA_WRTA), 0);

        @(negedge CLOCK_50);
        RESET = 1'b1;
        capture(NSMP);

        for (int e = 1; e <= 5; e++)
            check($sformatf("first_e%0d", e), samp[e], first_exp[e]);

        // Symbol k is latched on edge 1+8k; edge 2+8k shows -Q, edge 5+8k shows +I.
        m = 7'h7F;
        seen = 16'h0000;
        for (int k = 0; k < 127; k++) begin
            sym = m[3:0];
            seen[sym] = 1'b1;
            check($sformatf("map_q_s%0d", k), samp[2 + SPS * k], 8192 - gray(sym[1:0]) * 2047);
            check($sformatf("map_i_s%0d", k), samp[5 + SPS * k], 8192 + gray(sym[3:2]) * 2047);
            for (int a = 0; a < SPS; a++) m = {m[5:0], m[6] ^ m[5]};
        end
        check("all_symbols", int'(seen), 32'h0000FFFF);

        illegal = 0;
        for (int e = 2; e <= NSMP; e++) begin
            v = samp[e];
            if (v != 2051 && v != 6145 && v != 10239 && v != 14333) illegal++;
        end
        check("legal_codes", illegal, 0);

        mism = 0;
        for (int e = 2; e + PER <= NSMP; e++)
            if (samp[e] != samp[e + PER]) mism++;
        check("period_1016", mism, 0);
        mism = 0;
        for (int e = 2; e + 1 <= NSMP; e++)
            if (samp[e] != samp[e + 1]) mism++;
        check("not_constant", int'(mism > 0), 1);

        for (int k = 0; k < 16; k++) begin
            check($sformatf("sym_ph2_s%0d", k), samp[3 + SPS * k], 16384 - samp[5 + SPS * k]);
            check($sformatf("sym_ph3_s%0d", k), samp[4 + SPS * k], 16384 - samp[2 + SPS * k]);
        end

        // Reset pulse a few clocks into a symbol, away from the active edge.
        repeat (3) @(posedge CLOCK_50);
        #3;
        RESET = 1'b0;
        #1;
        check("mid_rst_async", int'(dac_if.DAC_OUT), 8192);
        check("mid_rst_mode", int'(dac_if.DA_MODE), 1);
        #4;
        RESET = 1'b1;
        capture(5);
        for (int e = 1; e <= 5; e++)
            check($sformatf("rerun_e%0d", e), samp[e], first_exp[e]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
